// File: rtl/aer_pkg.sv
// Shared definitions for the AER receive path: event word layout,
// marker word and the front-end FSM state encoding.
package aer_pkg;

    localparam int AER_WORD_W = 24;
    localparam int MARK_BIT   = 23;
    localparam int TS_LSB     = 8;
    localparam int ADDR_LSB   = 0;

    localparam logic [AER_WORD_W-1:0] MARKER_WORD = 24'h80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WRITE,
        S_ACK,
        S_MARK
    } aer_state_e;

endpackage

// File: rtl/aer_rx_frontend_if.sv
// Sensor handshake plus FIFO write port of the AER receiver, bundled so the
// sensor/FIFO environment (master) and the front end (slave) share one port.
interface aer_rx_frontend_if #(
    parameter int ADDR_W = 8
);
    logic                            aer_req;
    logic [ADDR_W-1:0]               aer_addr;
    logic                            aer_ack;
    logic                            fifo_full;
    logic                            fifo_wr_en;
    logic [aer_pkg::AER_WORD_W-1:0]  fifo_din;

    modport master (
        output aer_req, aer_addr, fifo_full,
        input  aer_ack, fifo_wr_en, fifo_din
    );

    modport slave (
        input  aer_req, aer_addr, fifo_full,
        output aer_ack, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/aer_sync2.sv
// Two-flop synchroniser for a single asynchronous AER control line.
module aer_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/aer_rx_frontend.sv
// AER receiver front end: 4-phase handshake with the sensor, timestamping,
// and one 24-bit event or wrap-marker word per FIFO write.
module aer_rx_frontend
    import aer_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TS_W     = 15,
    parameter int TICK_DIV = 100,
    parameter int SETTLE   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    aer_rx_frontend_if.slave    bus,
    output logic                stall
);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    aer_state_e              state;
    logic                    req_s;
    logic [PRESC_W-1:0]      presc;
    logic [TS_W-1:0]         ts;
    logic                    wrap_pend;
    logic [CNT_W-1:0]        cnt;
    logic [AER_WORD_W-1:0]   evt;
    logic                    tick;
    logic                    write_ok;
    logic                    mark_done;

    aer_sync2 u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.aer_req),
        .q   (req_s)
    );

    assign tick      = (presc == PRESC_W'(TICK_DIV - 1));
    // The gap cycle after every write lets fifo_full catch up with it.
    assign write_ok  = !bus.fifo_full && !bus.fifo_wr_en;
    assign mark_done = (state == S_MARK) && write_ok;
    assign stall     = ((state == S_WRITE) || (state == S_MARK)) && !write_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            ts        <= '0;
            wrap_pend <= 1'b0;
        end else if (!en) begin
            presc     <= '0;
            ts        <= '0;
            wrap_pend <= 1'b0;
        end else begin
            if (tick) begin
                presc <= '0;
                ts    <= ts + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (tick && (ts == '1))
                wrap_pend <= 1'b1;
            else if (mark_done)
                wrap_pend <= 1'b0;
        end
    end

    // Markers win in IDLE; a waiting sensor keeps req high, so it is served next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            evt            <= '0;
            bus.aer_ack    <= 1'b0;
            bus.fifo_wr_en <= 1'b0;
            bus.fifo_din   <= '0;
        end else begin
            bus.fifo_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wrap_pend) begin
                        state <= S_MARK;
                    end else if (en && req_s) begin
                        cnt   <= CNT_W'(SETTLE - 1);
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        evt[MARK_BIT]            <= 1'b0;
                        evt[TS_LSB +: TS_W]      <= ts;
                        evt[ADDR_LSB +: ADDR_W]  <= bus.aer_addr;
                        state                    <= S_WRITE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    if (write_ok) begin
                        bus.fifo_din   <= evt;
                        bus.fifo_wr_en <= 1'b1;
                        bus.aer_ack    <= 1'b1;
                        state          <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!req_s) begin
                        bus.aer_ack <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_MARK: begin
                    if (write_ok) begin
                        bus.fifo_din   <= MARKER_WORD;
                        bus.fifo_wr_en <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
